dm_writeback_data_cache: RTL and testbench

- Direct-mapped, write-back, write-allocate data cache between the CPU load/store path and the 32-bit-wide data memory.
- The CPU side is byte-wide with an 8-bit address. The memory side moves whole 4-byte blocks over a 6-bit block address.
- BUSYWAIT stalls the CPU's program counter and register write until the access completes.

---
 rtl/dm_writeback_data_cache.sv | 133 +++++++++++++
 tb/tb_dm_writeback_data_cache.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_writeback_data_cache.sv
// Direct-mapped, write-back, write-allocate byte cache in front of a 32-bit block memory.
// Hits complete with zero wait; misses walk WB (dirty victim only) -> FETCH -> FILL before the hit cycle.
module dm_writeback_data_cache #(
   parameter int INDEX_BITS = 3
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        READ,
   input  logic        WRITE,
   input  logic [7:0]  ADDRESS,
   input  logic [7:0]  WRITEDATA,
   output logic [7:0]  READDATA,
   output logic        BUSYWAIT,
   output logic        MEM_READ,
   output logic        MEM_WRITE,
   output logic [5:0]  MEM_ADDRESS,
   output logic [31:0] MEM_WRITEDATA,
   input  logic [31:0] MEM_READDATA,
   input  logic        MEM_BUSYWAIT
);

   localparam int TAG_W      = 6 - INDEX_BITS;
   localparam int NUM_BLOCKS = 1 << INDEX_BITS;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WB    = 2'd1,
      S_FETCH = 2'd2,
      S_FILL  = 2'd3
   } state_t;

   state_t                r_state;
   logic [NUM_BLOCKS-1:0] r_valid;
   logic [NUM_BLOCKS-1:0] r_dirty;
   logic [TAG_W-1:0]      r_tag  [NUM_BLOCKS];
   logic [31:0]           r_data [NUM_BLOCKS];
   logic                  r_mem_read;
   logic                  r_mem_write;
   logic [5:0]            r_mem_address;
   logic [31:0]           r_mem_writedata;

   logic [INDEX_BITS-1:0] w_index;
   logic [TAG_W-1:0]      w_tag;
   logic [1:0]            w_offset;
   logic [4:0]            w_bit_base;
   logic                  w_request;
   logic                  w_hit;
   logic [31:0]           w_block;
   logic [7:0]            w_byte;
   logic                  w_write_hit;

   // CPU handshake: READ/WRITE is a level request; it completes on the first rising
   // edge where BUSYWAIT is low, and ADDRESS/WRITEDATA/READ/WRITE stay stable until then.
   assign w_index     = ADDRESS[2 +: INDEX_BITS];
   assign w_tag       = ADDRESS[7 -: TAG_W];
   assign w_offset    = ADDRESS[1:0];
   assign w_bit_base  = {w_offset, 3'b000};
   assign w_request   = READ | WRITE;
   assign w_hit       = r_valid[w_index] && (r_tag[w_index] == w_tag);
   assign w_block     = r_data[w_index];
   assign w_byte      = w_block[w_bit_base +: 8];
   assign w_write_hit = (r_state == S_IDLE) && WRITE && w_hit;

   assign READDATA      = (!RESET && READ && w_hit && (r_state == S_IDLE)) ? w_byte : 8'h00;
   assign BUSYWAIT      = !RESET && ((r_state != S_IDLE) || (w_request && !w_hit));
   assign MEM_READ      = r_mem_read;
   assign MEM_WRITE     = r_mem_write;
   assign MEM_ADDRESS   = r_mem_address;
   assign MEM_WRITEDATA = r_mem_writedata;

   // Control FSM plus valid/dirty bits; memory-side outputs are registered with the state.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_state         <= S_IDLE;
         r_valid         <= '0;
         r_dirty         <= '0;
         r_mem_read      <= 1'b0;
         r_mem_write     <= 1'b0;
         r_mem_address   <= 6'h00;
         r_mem_writedata <= 32'h0000_0000;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_request && !w_hit) begin
                  if (r_valid[w_index] && r_dirty[w_index]) begin
                     r_state         <= S_WB;
                     r_mem_write     <= 1'b1;
                     r_mem_address   <= {r_tag[w_index], w_index};
                     r_mem_writedata <= w_block;
                  end else begin
                     r_state       <= S_FETCH;
                     r_mem_read    <= 1'b1;
                     r_mem_address <= ADDRESS[7:2];
                  end
               end else if (w_write_hit) begin
                  r_dirty[w_index] <= 1'b1;
               end
            end
            S_WB: begin
               if (!MEM_BUSYWAIT) begin
                  r_state       <= S_FETCH;
                  r_mem_write   <= 1'b0;
                  r_mem_read    <= 1'b1;
                  r_mem_address <= ADDRESS[7:2];
               end
            end
            S_FETCH: begin
               if (!MEM_BUSYWAIT) begin
                  r_state    <= S_FILL;
                  r_mem_read <= 1'b0;
               end
            end
            S_FILL: begin
               r_state          <= S_IDLE;
               r_valid[w_index] <= 1'b1;
               r_dirty[w_index] <= 1'b0;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Tag and data arrays carry no reset; valid gates every use of them.
   always_ff @(posedge CLK) begin
      if (r_state == S_FILL) begin
         r_data[w_index] <= MEM_READDATA;
         r_tag[w_index]  <= w_tag;
      end else if (w_write_hit) begin
         r_data[w_index][w_bit_base +: 8] <= WRITEDATA;
      end
   end

endmodule

// File: tb/tb_dm_writeback_data_cache.sv
// Directed bench for dm_writeback_data_cache with a fixed-latency block memory model.
// Memory holds MEM_BUSYWAIT high for MEM_LAT cycles of a request, then completes it.
module tb_dm_writeback_data_cache;

   localparam int MEM_LAT = 3;

   logic        CLK;
   logic        RESET;
   logic        READ;
   logic        WRITE;
   logic [7:0]  ADDRESS;
   logic [7:0]  WRITEDATA;
   logic [7:0]  READDATA;
   logic        BUSYWAIT;
   logic        MEM_READ;
   logic        MEM_WRITE;
   logic [5:0]  MEM_ADDRESS;
   logic [31:0] MEM_WRITEDATA;
   logic [31:0] MEM_READDATA;
   logic        MEM_BUSYWAIT;

   int n_checks = 0;
   int n_fail   = 0;
   int n_wait;
   bit wr_seen;

   dm_writeback_data_cache #(.INDEX_BITS(3)) dut (
      .CLK           (CLK),
      .RESET         (RESET),
      .READ          (READ),
      .WRITE         (WRITE),
      .ADDRESS       (ADDRESS),
      .WRITEDATA     (WRITEDATA),
      .READDATA      (READDATA),
      .BUSYWAIT      (BUSYWAIT),
      .MEM_READ      (MEM_READ),
      .MEM_WRITE     (MEM_WRITE),
      .MEM_ADDRESS   (MEM_ADDRESS),
      .MEM_WRITEDATA (MEM_WRITEDATA),
      .MEM_READDATA  (MEM_READDATA),
      .MEM_BUSYWAIT  (MEM_BUSYWAIT)
   );

   // clock/reset
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // block memory model
   logic [31:0] mem [64];
   int          mem_cnt;
   logic [31:0] mem_rdata;

   assign MEM_BUSYWAIT = (MEM_READ || MEM_WRITE) && (mem_cnt < MEM_LAT);
   assign MEM_READDATA = mem_rdata;

   always @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         mem_cnt   <= 0;
         mem_rdata <= 32'h0;
         for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
         mem[1]  <= 32'hDDCC_BBAA;
         mem[9]  <= 32'h4433_2211;
         mem[63] <= 32'h1234_5678;
      end else if (MEM_READ || MEM_WRITE) begin
         if (mem_cnt < MEM_LAT) begin
            mem_cnt <= mem_cnt + 1;
         end else begin
            mem_cnt <= 0;
            if (MEM_WRITE) mem[MEM_ADDRESS] <= MEM_WRITEDATA;
            else           mem_rdata        <= mem[MEM_ADDRESS];
         end
      end
   end

   // driver tasks
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance while the selected memory strobe is high; bounded so a stuck FSM still reports.
   task automatic wait_strobe(input bit is_write, output int n, output bit saw_wr);
      n      = 0;
      saw_wr = 1'b0;
      while ((is_write ? MEM_WRITE : MEM_READ) && (n < 50)) begin
         saw_wr = saw_wr | MEM_WRITE;
         step();
         n++;
      end
   endtask

   task automatic cpu(input logic rd, input logic wr, input logic [7:0] addr, input logic [7:0] wdata);
      READ      = rd;
      WRITE     = wr;
      ADDRESS   = addr;
      WRITEDATA = wdata;
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      READ = 0; WRITE = 0; ADDRESS = 8'h00; WRITEDATA = 8'h00; RESET = 0;
      #2 RESET = 1;
      step(); step(); #1;
      check("rst_busywait",  BUSYWAIT,      1'b0);
      check("rst_mem_read",  MEM_READ,      1'b0);
      check("rst_mem_write", MEM_WRITE,     1'b0);
      check("rst_mem_addr",  MEM_ADDRESS,   6'h00);
      check("rst_mem_wdata", MEM_WRITEDATA, 32'h0);
      check("rst_readdata",  READDATA,      8'h00);
      RESET = 0;

      // read miss on clean block 1
      step();
      cpu(1, 0, 8'h04, 8'h00);
      check("t1_miss_busy",   BUSYWAIT, 1'b1);
      check("t1_miss_noreq",  MEM_READ, 1'b0);
      step();
      check("t1_fetch_rd",    MEM_READ,    1'b1);
      check("t1_fetch_addr",  MEM_ADDRESS, 6'h01);
      check("t1_fetch_nowr",  MEM_WRITE,   1'b0);
      wait_strobe(0, n_wait, wr_seen);
      check("t1_fetch_cycles", n_wait, MEM_LAT + 1);
      check("t1_fill_busy",   BUSYWAIT, 1'b1);
      check("t1_fill_rd",     MEM_READ, 1'b0);
      step();
      check("t1_hit_busy",    BUSYWAIT, 1'b0);
      check("t1_hit_data",    READDATA, 8'hAA);
      step();
      cpu(1, 0, 8'h07, 8'h00);
      check("t1_off3_busy",   BUSYWAIT, 1'b0);
      check("t1_off3_data",   READDATA, 8'hDD);

      // write hit
      step();
      cpu(0, 1, 8'h06, 8'h5A);
      check("t2_wr_busy",     BUSYWAIT,  1'b0);
      check("t2_wr_memrd",    MEM_READ,  1'b0);
      check("t2_wr_memwr",    MEM_WRITE, 1'b0);
      check("t2_noread_data", READDATA,  8'h00);
      step();
      cpu(1, 0, 8'h06, 8'h00);
      check("t2_rd_busy",     BUSYWAIT, 1'b0);
      check("t2_rd_data",     READDATA, 8'h5A);

      // conflicting read with dirty victim
      step();
      cpu(1, 0, 8'h24, 8'h00);
      check("t3_miss_busy",   BUSYWAIT, 1'b1);
      step();
      check("t3_wb_wr",       MEM_WRITE,     1'b1);
      check("t3_wb_rd",       MEM_READ,      1'b0);
      check("t3_wb_addr",     MEM_ADDRESS,   6'h01);
      check("t3_wb_data",     MEM_WRITEDATA, 32'hDD5A_BBAA);
      wait_strobe(1, n_wait, wr_seen);
      check("t3_wb_cycles",   n_wait, MEM_LAT + 1);
      check("t3_fetch_rd",    MEM_READ,    1'b1);
      check("t3_fetch_addr",  MEM_ADDRESS, 6'h09);
      check("t3_mem1_written", mem[1], 32'hDD5A_BBAA);
      wait_strobe(0, n_wait, wr_seen);
      check("t3_fetch_cycles", n_wait, MEM_LAT + 1);
      check("t3_fill_busy",   BUSYWAIT, 1'b1);
      step();
      check("t3_hit_busy",    BUSYWAIT, 1'b0);
      check("t3_hit_data",    READDATA, 8'h11);

      // write miss on invalid block 7, highest address
      step();
      cpu(0, 1, 8'hFF, 8'h77);
      check("t4_miss_busy",   BUSYWAIT, 1'b1);
      step();
      check("t4_fetch_rd",    MEM_READ,    1'b1);
      check("t4_fetch_addr",  MEM_ADDRESS, 6'h3F);
      wait_strobe(0, n_wait, wr_seen);
      check("t4_fetch_cycles", n_wait, MEM_LAT + 1);
      check("t4_no_memwrite", wr_seen, 1'b0);
      check("t4_fill_busy",   BUSYWAIT, 1'b1);
      step();
      check("t4_hit_busy",    BUSYWAIT, 1'b0);
      step();
      cpu(1, 0, 8'hFF, 8'h00);
      check("t4_rd_ff",       READDATA, 8'h77);
      cpu(1, 0, 8'hFE, 8'h00);
      check("t4_rd_fe",       READDATA, 8'h34);
      // tag 0 on index 7 evicts the now-dirty block
      cpu(1, 0, 8'h1F, 8'h00);
      check("t5_miss_busy",   BUSYWAIT, 1'b1);
      step();
      check("t5_wb_wr",       MEM_WRITE,     1'b1);
      check("t5_wb_addr",     MEM_ADDRESS,   6'h3F);
      check("t5_wb_data",     MEM_WRITEDATA, 32'h7734_5678);
      wait_strobe(1, n_wait, wr_seen);
      check("t5_fetch_addr",  MEM_ADDRESS, 6'h07);
      check("t5_fetch_rd",    MEM_READ,    1'b1);

      // reset in the middle of the fetch
      step();
      RESET = 1;
      #1;
      check("t5_rst_memrd",   MEM_READ,    1'b0);
      check("t5_rst_busy",    BUSYWAIT,    1'b0);
      check("t5_rst_addr",    MEM_ADDRESS, 6'h00);
      check("t5_rst_rdata",   READDATA,    8'h00);
      cpu(0, 0, 8'h00, 8'h00);
      step();
      RESET = 0;
      step();
      cpu(1, 0, 8'h04, 8'h00);
      check("t5_remiss_busy", BUSYWAIT, 1'b1);
      step();
      check("t5_refetch_rd",   MEM_READ,    1'b1);
      check("t5_refetch_nowb", MEM_WRITE,   1'b0);
      check("t5_refetch_addr", MEM_ADDRESS, 6'h01);
      wait_strobe(0, n_wait, wr_seen);
      check("t5_refetch_cycles", n_wait, MEM_LAT + 1);
      step();
      check("t5_rehit_busy",  BUSYWAIT, 1'b0);
      check("t5_rehit_data",  READDATA, 8'hAA);

      // simultaneous READ and WRITE on a hit
      step();
      cpu(1, 1, 8'h05, 8'hC3);
      check("t6_rw_busy",     BUSYWAIT,  1'b0);
      check("t6_rw_old",      READDATA,  8'hBB);
      check("t6_rw_nomem",    MEM_READ,  1'b0);
      step();
      cpu(1, 0, 8'h05, 8'h00);
      check("t6_rw_new",      READDATA,  8'hC3);
      check("t6_rw_neighbor", BUSYWAIT,  1'b0);
      cpu(0, 0, 8'h00, 8'h00);
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
